// File: rtl/ets_ctrl_pkg.sv
// Shared definitions for the ETS sweep scheduler: FSM encoding, default
// MMCM phase-shift geometry and phase-shift direction codes.
package ets_ctrl_pkg;

    localparam int PS_PERIOD_DEFAULT     = 1120;
    localparam int PS_TIMEOUT_DEFAULT    = 1023;
    localparam int SETTLE_CYCLES_DEFAULT = 16;

    localparam logic PS_INC = 1'b1;
    localparam logic PS_DEC = 1'b0;

    typedef enum logic [3:0] {
        IDLE,
        LAUNCH,
        RUN,
        PS_REQ,
        PS_WAIT,
        ACK,
        UNWIND_REQ,
        UNWIND_WAIT,
        SETTLE,
        FINISH,
        ERROR
    } state_t;

endpackage

// File: rtl/ets_ps_driver.sv
// Single-step MMCM phase-shift handshake: presents psen/psincdec, waits for
// psdone and raises a timeout pulse if the MMCM never answers.
module ets_ps_driver #(
    parameter int PS_TIMEOUT = 1023
) (
    input  logic sample_clk,
    input  logic rst_n,
    input  logic req,
    input  logic dir,
    input  logic psdone,
    output logic psen,
    output logic psincdec,
    output logic done,
    output logic timeout
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(PS_TIMEOUT - 1);

    logic        waiting_reg;
    logic [15:0] wdog_reg;

    // The request is already a registered one-cycle pulse from the scheduler.
    assign psen     = req;
    assign psincdec = dir;
    assign done     = waiting_reg & psdone;
    assign timeout  = waiting_reg & ~psdone & (wdog_reg >= TIMEOUT_LAST);

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            waiting_reg <= 1'b0;
            wdog_reg    <= 16'd0;
        end else if (req) begin
            waiting_reg <= 1'b1;
            wdog_reg    <= 16'd1;
        end else if (done || timeout) begin
            waiting_reg <= 1'b0;
            wdog_reg    <= 16'd0;
        end else if (waiting_reg) begin
            wdog_reg    <= wdog_reg + 16'd1;
        end
    end

endmodule

// File: rtl/ets_sweep_scheduler.sv
// Runs repeated ETS sweeps: launches the core, answers its shift requests with
// MMCM phase steps, and unwinds the accumulated phase after every sweep.
module ets_sweep_scheduler
    import ets_ctrl_pkg::*;
#(
    parameter int PS_PERIOD     = PS_PERIOD_DEFAULT,
    parameter int PS_TIMEOUT    = PS_TIMEOUT_DEFAULT,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic        sample_clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic [15:0] cfg_num_sweeps,
    input  logic [31:0] cfg_avg,
    input  logic [3:0]  cfg_step_mult,
    output logic        ets_start,
    output logic [31:0] ets_vernier_q,
    input  logic        ets_shift,
    output logic        ets_shift_done,
    input  logic        ets_valid,
    input  logic        ets_ready,
    input  logic        ets_tlast,
    output logic        psen,
    output logic        psincdec,
    input  logic        psdone,
    output logic        busy,
    output logic        run_done,
    output logic        err_timeout,
    output logic [15:0] sweep_count,
    output logic [15:0] phase_acc
);

    localparam logic [15:0] PERIOD_M1   = 16'(PS_PERIOD - 1);
    localparam logic [15:0] PERIOD_HALF = 16'(PS_PERIOD / 2);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    state_t      state_reg;
    logic [15:0] num_sweeps_reg;
    logic [3:0]  step_mult_reg;
    logic [3:0]  step_left_reg;
    logic [15:0] settle_cnt_reg;
    logic        stop_reg;
    logic        ets_start_reg;
    logic        shift_done_reg;
    logic        psen_reg;
    logic        psincdec_reg;
    logic        run_done_reg;
    logic        err_reg;
    logic [15:0] sweep_count_reg;
    logic [15:0] phase_acc_reg;
    logic [31:0] vernier_reg;
    logic        ps_done;
    logic        ps_timeout;
    logic        tlast_beat;

    assign tlast_beat = ets_valid & ets_ready & ets_tlast;

    function automatic logic [15:0] phase_step(input logic [15:0] p, input logic inc);
        if (inc)
            return (p == PERIOD_M1) ? 16'd0 : p + 16'd1;
        else
            return (p == 16'd0) ? PERIOD_M1 : p - 16'd1;
    endfunction

    ets_ps_driver #(
        .PS_TIMEOUT (PS_TIMEOUT)
    ) u_ps_driver (
        .sample_clk (sample_clk),
        .rst_n      (rst_n),
        .req        (psen_reg),
        .dir        (psincdec_reg),
        .psdone     (psdone),
        .psen       (psen),
        .psincdec   (psincdec),
        .done       (ps_done),
        .timeout    (ps_timeout)
    );

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            num_sweeps_reg  <= 16'd0;
            step_mult_reg   <= 4'd0;
            step_left_reg   <= 4'd0;
            settle_cnt_reg  <= 16'd0;
            stop_reg        <= 1'b0;
            ets_start_reg   <= 1'b0;
            shift_done_reg  <= 1'b0;
            psen_reg        <= 1'b0;
            psincdec_reg    <= 1'b0;
            run_done_reg    <= 1'b0;
            err_reg         <= 1'b0;
            sweep_count_reg <= 16'd0;
            phase_acc_reg   <= 16'd0;
            vernier_reg     <= 32'd0;
        end else begin
            ets_start_reg  <= 1'b0;
            shift_done_reg <= 1'b0;
            psen_reg       <= 1'b0;
            run_done_reg   <= 1'b0;
            if (cfg_stop && state_reg != IDLE && state_reg != ERROR)
                stop_reg <= 1'b1;
            case (state_reg)
                IDLE: if (cfg_start) begin
                    num_sweeps_reg  <= cfg_num_sweeps;
                    vernier_reg     <= cfg_avg;
                    step_mult_reg   <= cfg_step_mult;
                    sweep_count_reg <= 16'd0;
                    stop_reg        <= 1'b0;
                    if (cfg_num_sweeps == 16'd0) begin
                        run_done_reg <= 1'b1;
                        state_reg    <= FINISH;
                    end else begin
                        ets_start_reg <= 1'b1;
                        state_reg     <= LAUNCH;
                    end
                end
                LAUNCH: state_reg <= RUN;
                RUN: if (tlast_beat) begin
                    sweep_count_reg <= sweep_count_reg + 16'd1;
                    state_reg       <= UNWIND_REQ;
                end else if (ets_shift) begin
                    if (step_mult_reg == 4'd0) begin
                        shift_done_reg <= 1'b1;
                        state_reg      <= ACK;
                    end else begin
                        step_left_reg <= step_mult_reg;
                        psen_reg      <= 1'b1;
                        psincdec_reg  <= PS_INC;
                        state_reg     <= PS_REQ;
                    end
                end
                PS_REQ: state_reg <= PS_WAIT;
                PS_WAIT: if (ps_done) begin
                    phase_acc_reg <= phase_step(phase_acc_reg, PS_INC);
                    step_left_reg <= step_left_reg - 4'd1;
                    if (step_left_reg != 4'd1) begin
                        psen_reg  <= 1'b1;
                        state_reg <= PS_REQ;
                    end else begin
                        shift_done_reg <= 1'b1;
                        state_reg      <= ACK;
                    end
                end else if (ps_timeout) begin
                    err_reg   <= 1'b1;
                    state_reg <= ERROR;
                end
                ACK: state_reg <= RUN;
                // Take the shorter way back to zero; ties go downward.
                UNWIND_REQ: if (phase_acc_reg == 16'd0) begin
                    settle_cnt_reg <= 16'd0;
                    state_reg      <= SETTLE;
                end else begin
                    psen_reg     <= 1'b1;
                    psincdec_reg <= (phase_acc_reg <= PERIOD_HALF) ? PS_DEC : PS_INC;
                    state_reg    <= UNWIND_WAIT;
                end
                UNWIND_WAIT: if (ps_done) begin
                    phase_acc_reg <= phase_step(phase_acc_reg, psincdec_reg);
                    state_reg     <= UNWIND_REQ;
                end else if (ps_timeout) begin
                    err_reg   <= 1'b1;
                    state_reg <= ERROR;
                end
                SETTLE: if (settle_cnt_reg == SETTLE_LAST) begin
                    if (sweep_count_reg == num_sweeps_reg || stop_reg || cfg_stop) begin
                        run_done_reg <= 1'b1;
                        state_reg    <= FINISH;
                    end else begin
                        ets_start_reg <= 1'b1;
                        state_reg     <= LAUNCH;
                    end
                end else begin
                    settle_cnt_reg <= settle_cnt_reg + 16'd1;
                end
                FINISH: state_reg <= IDLE;
                ERROR: if (cfg_start) begin
                    err_reg       <= 1'b0;
                    phase_acc_reg <= 16'd0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy           = (state_reg != IDLE) && (state_reg != ERROR);
    assign ets_start      = ets_start_reg;
    assign ets_vernier_q  = vernier_reg;
    assign ets_shift_done = shift_done_reg;
    assign run_done       = run_done_reg;
    assign err_timeout    = err_reg;
    assign sweep_count    = sweep_count_reg;
    assign phase_acc      = phase_acc_reg;

endmodule

// File: tb/tb_ets_sweep_scheduler.sv
// Directed bench for ets_sweep_scheduler with a small MMCM responder model;
// uses an 8-step phase period so wrap-around unwinding is reachable.
module tb_ets_sweep_scheduler;

    logic        sample_clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_stop;
    logic [15:0] cfg_num_sweeps;
    logic [31:0] cfg_avg;
    logic [3:0]  cfg_step_mult;
    logic        ets_start;
    logic [31:0] ets_vernier_q;
    logic        ets_shift;
    logic        ets_shift_done;
    logic        ets_valid;
    logic        ets_ready;
    logic        ets_tlast;
    logic        psen;
    logic        psincdec;
    logic        psdone = 1'b0;
    logic        busy;
    logic        run_done;
    logic        err_timeout;
    logic [15:0] sweep_count;
    logic [15:0] phase_acc;

    int checks   = 0;
    int failures = 0;
    int n_start = 0, n_inc = 0, n_dec = 0, n_done = 0, n_sdone = 0;
    int b_start, b_inc, b_dec, b_done, b_sdone;
    logic mmcm_en = 1'b1;
    int   mmcm_cnt = 0;

    ets_sweep_scheduler #(
        .PS_PERIOD (8)
    ) dut (
        .sample_clk     (sample_clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_num_sweeps (cfg_num_sweeps),
        .cfg_avg        (cfg_avg),
        .cfg_step_mult  (cfg_step_mult),
        .ets_start      (ets_start),
        .ets_vernier_q  (ets_vernier_q),
        .ets_shift      (ets_shift),
        .ets_shift_done (ets_shift_done),
        .ets_valid      (ets_valid),
        .ets_ready      (ets_ready),
        .ets_tlast      (ets_tlast),
        .psen           (psen),
        .psincdec       (psincdec),
        .psdone         (psdone),
        .busy           (busy),
        .run_done       (run_done),
        .err_timeout    (err_timeout),
        .sweep_count    (sweep_count),
        .phase_acc      (phase_acc)
    );

    always #5 sample_clk = ~sample_clk;

    // MMCM model: psdone arrives 5 cycles after the psen cycle.
    always @(posedge sample_clk) begin
        psdone <= 1'b0;
        if (mmcm_cnt != 0) begin
            mmcm_cnt <= mmcm_cnt - 1;
            if (mmcm_cnt == 1) psdone <= 1'b1;
        end
        if (psen && mmcm_en) mmcm_cnt <= 4;
    end

    always @(posedge sample_clk) begin
        if (rst_n) begin
            if (ets_start)         n_start++;
            if (psen && psincdec)  n_inc++;
            if (psen && !psincdec) n_dec++;
            if (run_done)          n_done++;
            if (ets_shift_done)    n_sdone++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic snap();
        b_start = n_start; b_inc = n_inc; b_dec = n_dec; b_done = n_done; b_sdone = n_sdone;
    endtask

    task automatic start_run(input logic [15:0] n, input logic [3:0] sm, input logic [31:0] avg);
        @(negedge sample_clk);
        cfg_num_sweeps = n; cfg_step_mult = sm; cfg_avg = avg; cfg_start = 1'b1;
        @(negedge sample_clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!ets_start && n < 3000) begin @(negedge sample_clk); n++; end
        check(tag, 32'(ets_start), 32'd1);
    endtask

    task automatic do_shift(output int lat);
        @(negedge sample_clk);
        ets_shift = 1'b1;
        lat = 0;
        do begin
            @(negedge sample_clk);
            ets_shift = 1'b0;
            lat++;
        end while (!ets_shift_done && lat < 3000);
    endtask

    task automatic do_tlast();
        @(negedge sample_clk);
        ets_valid = 1'b1; ets_ready = 1'b1; ets_tlast = 1'b1;
        @(negedge sample_clk);
        ets_valid = 1'b0; ets_ready = 1'b0; ets_tlast = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!run_done && n < 5000) begin @(negedge sample_clk); n++; end
        check(tag, 32'(run_done), 32'd1);
        @(negedge sample_clk);
    endtask

    task automatic wait_phase(input string tag, input logic [15:0] exp);
        int n = 0;
        logic [15:0] p0;
        p0 = phase_acc;
        while (phase_acc == p0 && n < 3000) begin @(negedge sample_clk); n++; end
        check(tag, 32'(phase_acc), 32'(exp));
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int cnt;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_num_sweeps = 16'd0;
        cfg_avg = 32'd0; cfg_step_mult = 4'd0; ets_shift = 1'b0;
        ets_valid = 1'b0; ets_ready = 1'b0; ets_tlast = 1'b0;
        repeat (3) @(negedge sample_clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_psen", 32'(psen), 32'd0);
        check("rst_start", 32'(ets_start), 32'd0);
        check("rst_sweep_count", 32'(sweep_count), 32'd0);
        check("rst_phase", 32'(phase_acc), 32'd0);
        check("rst_vernier", ets_vernier_q, 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        rst_n = 1'b1;

        // Basic run: 2 sweeps, 3 single-step shifts each
        snap();
        start_run(16'd2, 4'd1, 32'hCAFE_0123);
        check("basic_busy", 32'(busy), 32'd1);
        for (int sw = 0; sw < 2; sw++) begin
            wait_start("basic_start");
            check("basic_vernier", ets_vernier_q, 32'hCAFE_0123);
            for (int i = 0; i < 3; i++) begin
                do_shift(lat);
                if (i == 0) check("basic_shift_lat", 32'(lat), 32'd7);
            end
            do_tlast();
            check("basic_sweep_count", 32'(sweep_count), 32'(sw + 1));
            check("basic_phase_pre_unwind", 32'(phase_acc), 32'd3);
        end
        wait_done("basic_run_done");
        check("basic_n_start", 32'(n_start - b_start), 32'd2);
        check("basic_n_inc", 32'(n_inc - b_inc), 32'd6);
        check("basic_n_dec", 32'(n_dec - b_dec), 32'd6);
        check("basic_n_done", 32'(n_done - b_done), 32'd1);
        check("basic_phase_end", 32'(phase_acc), 32'd0);
        check("basic_sweeps_end", 32'(sweep_count), 32'd2);
        check("basic_idle_busy", 32'(busy), 32'd0);

        // Wrap-around: 2 shifts of 3 steps reach 6 of 8, unwind goes up
        snap();
        start_run(16'd1, 4'd3, 32'h0000_0010);
        wait_start("wrap_start");
        do_shift(lat);
        check("wrap_shift_lat", 32'(lat), 32'd19);
        do_shift(lat);
        do_tlast();
        check("wrap_phase6", 32'(phase_acc), 32'd6);
        wait_phase("wrap_phase7", 16'd7);
        wait_phase("wrap_phase0", 16'd0);
        wait_done("wrap_run_done");
        check("wrap_n_inc", 32'(n_inc - b_inc), 32'd8);
        check("wrap_n_dec", 32'(n_dec - b_dec), 32'd0);

        // Zero-step shifts: immediate acknowledge, no MMCM activity
        snap();
        start_run(16'd1, 4'd0, 32'h0000_0020);
        wait_start("zero_start");
        do_shift(lat);
        check("zero_lat_a", 32'(lat), 32'd1);
        do_shift(lat);
        check("zero_lat_b", 32'(lat), 32'd1);
        do_tlast();
        wait_done("zero_run_done");
        check("zero_n_psen", 32'((n_inc - b_inc) + (n_dec - b_dec)), 32'd0);
        check("zero_n_sdone", 32'(n_sdone - b_sdone), 32'd2);

        // Graceful stop during sweep 1 of 4
        snap();
        start_run(16'd4, 4'd1, 32'h0000_0030);
        wait_start("stop_start");
        do_shift(lat);
        @(negedge sample_clk);
        cfg_stop = 1'b1;
        @(negedge sample_clk);
        cfg_stop = 1'b0;
        do_shift(lat);
        do_tlast();
        wait_done("stop_run_done");
        check("stop_n_start", 32'(n_start - b_start), 32'd1);
        check("stop_sweeps", 32'(sweep_count), 32'd1);
        check("stop_phase", 32'(phase_acc), 32'd0);
        check("stop_n_done", 32'(n_done - b_done), 32'd1);

        // Timeout: MMCM never answers
        mmcm_en = 1'b0;
        snap();
        start_run(16'd1, 4'd1, 32'h0000_0040);
        wait_start("to_start");
        @(negedge sample_clk);
        ets_shift = 1'b1;
        @(negedge sample_clk);
        ets_shift = 1'b0;
        check("to_psen", 32'(psen), 32'd1);
        cnt = 0;
        while (!err_timeout && cnt < 2000) begin @(negedge sample_clk); cnt++; end
        check("to_latency", 32'(cnt), 32'd1023);
        check("to_busy", 32'(busy), 32'd0);
        check("to_psen_low", 32'(psen), 32'd0);
        repeat (10) @(negedge sample_clk);
        check("to_no_sdone", 32'(n_sdone - b_sdone), 32'd0);
        check("to_err_sticky", 32'(err_timeout), 32'd1);
        start_run(16'd1, 4'd1, 32'h0000_0050);
        check("to_err_cleared", 32'(err_timeout), 32'd0);
        check("to_idle_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge sample_clk);
        check("to_no_restart", 32'(n_start - b_start), 32'd1);
        mmcm_en = 1'b1;

        // Reset asserted while waiting for psdone
        start_run(16'd2, 4'd1, 32'h0000_0060);
        wait_start("mrst_start");
        @(negedge sample_clk);
        ets_shift = 1'b1;
        @(negedge sample_clk);
        ets_shift = 1'b0;
        @(negedge sample_clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_psen", 32'(psen), 32'd0);
        check("mrst_vernier", ets_vernier_q, 32'd0);
        check("mrst_sweeps", 32'(sweep_count), 32'd0);
        repeat (10) @(negedge sample_clk);
        rst_n = 1'b1;
        snap();
        start_run(16'd1, 4'd1, 32'h0000_0070);
        wait_start("fresh_start");
        check("fresh_vernier", ets_vernier_q, 32'h0000_0070);
        do_shift(lat);
        check("fresh_shift_lat", 32'(lat), 32'd7);
        do_tlast();
        wait_done("fresh_run_done");
        check("fresh_sweeps", 32'(sweep_count), 32'd1);
        check("fresh_phase", 32'(phase_acc), 32'd0);
        check("fresh_n_inc", 32'(n_inc - b_inc), 32'd1);
        check("fresh_n_dec", 32'(n_dec - b_dec), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ets_sweep_scheduler.md
Name: ets_sweep_scheduler

Overview:
- Sequences repeated ETS acquisitions: pulses the ETS core's start, services its per-step shift requests by driving the MMCM dynamic phase-shift port, and detects end of sweep from the output stream's tlast.
- After each sweep, unwinds the accumulated MMCM phase back to origin before the next sweep starts.
- Sits between the AXI-Lite config registers, the ETS core and the sampling MMCM, all in the sample_clk domain.

Parameters:
- PS_PERIOD, 1120: MMCM phase-shift steps per full sample_clk period; the phase accumulator is modulo this value.
- PS_TIMEOUT, 1023: maximum cycles from psen to psdone before an error is flagged.
- SETTLE_CYCLES, 16: idle cycles after unwind completes, before the next ets_start.

Ports:
- sample_clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_start  in  1  single-cycle run request
- cfg_stop  in  1  single-cycle graceful stop request
- cfg_num_sweeps  in  16  number of sweeps per run
- cfg_avg  in  32  averaging count for the ETS adders
- cfg_step_mult  in  4  MMCM steps per ETS shift request
- ets_start  out  1  start pulse to the ETS core
- ets_vernier_q  out  32  latched cfg_avg, driven to the ETS core
- ets_shift  in  1  shift request pulse from the ETS core
- ets_shift_done  out  1  shift completion pulse to the ETS core
- ets_valid  in  1  ETS stream valid (monitor only)
- ets_ready  in  1  ETS stream ready (monitor only)
- ets_tlast  in  1  ETS stream last (monitor only)
- psen  out  1  MMCM phase-shift enable
- psincdec  out  1  MMCM phase-shift direction; 1 = increment
- psdone  in  1  MMCM phase-shift done
- busy  out  1  high while a run is active
- run_done  out  1  single-cycle pulse at the end of a run
- err_timeout  out  1  sticky psdone-timeout flag
- sweep_count  out  16  sweeps completed in the current run
- phase_acc  out  16  current phase offset, 0..PS_PERIOD-1

Behaviour:
- Reset values: all outputs 0; ets_vernier_q 0; state IDLE.
- States: IDLE, LAUNCH, RUN, PS_REQ, PS_WAIT, ACK, UNWIND_REQ, UNWIND_WAIT, SETTLE, FINISH, ERROR.
- IDLE:
  - On cfg_start, latch cfg_num_sweeps, cfg_avg and cfg_step_mult; clear sweep_count and the stop flag.
  - If the latched num_sweeps is 0, go to FINISH. Otherwise go to LAUNCH.
  - cfg_start is ignored in every state other than IDLE.
- busy: high in every state except IDLE and ERROR.
- LAUNCH:
  - ets_start is high for exactly one cycle, then the state moves to RUN.
  - ets_vernier_q holds the latched average for the whole run.
- RUN:
  - ets_shift with step_mult 0: go to ACK with no MMCM activity.
  - ets_shift with step_mult > 0: load step_left = step_mult and go to PS_REQ.
  - A beat with ets_valid & ets_ready & ets_tlast ends the sweep: sweep_count++, then go to UNWIND_REQ.
- PS_REQ: psen high for one cycle with psincdec = 1, then go to PS_WAIT.
- PS_WAIT:
  - On psdone: phase_acc = (phase_acc + 1) mod PS_PERIOD, step_left--.
  - If step_left is still non-zero, go to PS_REQ; otherwise go to ACK.
  - psen is never reasserted before psdone (MMCM rule).
- ACK: ets_shift_done high for one cycle, then return to RUN.
  - Minimum latency from ets_shift to ets_shift_done is 1 cycle with step_mult 0, and 2 cycles plus the psdone delay with step_mult 1.
- UNWIND_REQ:
  - If phase_acc is 0, go to SETTLE.
  - Direction uses the shorter path. If phase_acc ≤ PS_PERIOD/2, decrement (psincdec = 0). Otherwise increment, so the accumulator wraps to 0.
  - Issue one psen pulse per step and go to UNWIND_WAIT.
- UNWIND_WAIT: on psdone, update phase_acc by ±1 mod PS_PERIOD and return to UNWIND_REQ.
- SETTLE:
  - Count SETTLE_CYCLES cycles.
  - Then go to FINISH if sweep_count equals num_sweeps or the stop flag is set; otherwise go to LAUNCH.
- FINISH: run_done pulses for one cycle, then go to IDLE.
- cfg_stop:
  - In any busy state it sets the stop flag. It does not abort the current sweep, because the ETS core has no abort and an unanswered shift would hang it.
  - The current sweep completes, unwinds and then finishes.
  - In IDLE, cfg_stop is ignored.
- Timeout:
  - A watchdog counts cycles in PS_WAIT and UNWIND_WAIT. Reaching PS_TIMEOUT sets err_timeout and moves to ERROR.
  - In ERROR, psen = 0, busy = 0 and no ets_shift_done is issued.
  - Exit ERROR only via cfg_start: clear err_timeout and phase_acc, go to IDLE, and ignore that cfg_start as a run request.
- Simultaneous events:
  - ets_shift and a tlast beat in the same cycle: tlast takes priority and the shift is ignored. The ETS core never does both.
  - ets_shift outside RUN is ignored.
  - psdone outside a wait state is ignored.
- phase_acc persists across runs and is 0 after every successful run.
- Reset mid-operation returns to IDLE with all counters 0. The MMCM phase is not restored.

Decomposition:
- Package ets_ctrl_pkg: state encoding, PS_PERIOD and PS_TIMEOUT defaults, and PS direction constants.
- Sub-module ets_ps_driver: single-step psen/psdone handshake with the timeout watchdog. It takes a request and direction, and returns a done or timeout pulse. It is shared by the shift path and the unwind path.

Test Plan:
- Basic run:
  - Stimulus: num_sweeps = 2, step_mult = 1, ETS model issues 3 shifts then tlast, psdone 5 cycles after psen.
  - Required: 2 ets_start pulses; 3 psen increments per sweep; 3 decrements per unwind; phase_acc ends at 0; run_done pulses once; sweep_count = 2.
- Wrap-around:
  - Stimulus: PS_PERIOD = 8, step_mult = 3, 2 shifts (phase_acc = 6).
  - Required: unwind uses 2 increments, phase_acc goes 6 → 7 → 0.
- Zero-step shifts:
  - Stimulus: step_mult = 0.
  - Required: ets_shift_done exactly 1 cycle after ets_shift; psen is never asserted.
- Graceful stop:
  - Stimulus: cfg_stop in the middle of sweep 1 of 4.
  - Required: sweep 1 completes and unwinds; no second ets_start; sweep_count = 1; run_done pulses.
- Timeout:
  - Stimulus: psdone is never returned.
  - Required: err_timeout rises PS_TIMEOUT cycles after psen; busy = 0; no ets_shift_done.
  - Then: cfg_start clears err_timeout and returns the block to IDLE with no ets_start.
- Reset mid-run:
  - Stimulus: rst_n asserted during PS_WAIT.
  - Required: all outputs 0 immediately; a following cfg_start behaves as a fresh run.
